// File: rtl/pico_sequencer.sv
// pico_sequencer: picoMIPS control unit holding pc/ir, decoding opcodes, stalling MUL, parking on WAIT.
// Optional macro PICO_SINGLE_STEP_EN adds a 'step' input that gates each FETCH on a press edge.
module pico_sequencer #(
  parameter int unsigned P_SIZE     = 4,
  parameter int unsigned O_SIZE     = 3,
  parameter int unsigned A_SIZE     = 2,
  parameter int unsigned PROG_LEN   = 16,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              nReset,
`ifdef PICO_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [O_SIZE-1:0] opcode_in,
  input  logic              sw8,
  output logic [P_SIZE-1:0] pc,
  output logic [O_SIZE-1:0] ir_op,
  output logic [A_SIZE-1:0] alu_func,
  output logic              imm_sel,
  output logic              sw_sel,
  output logic              reg_we,
  output logic              waiting
);

  localparam logic [O_SIZE-1:0] OpLdi   = O_SIZE'(0);
  localparam logic [O_SIZE-1:0] OpLds   = O_SIZE'(1);
  localparam logic [O_SIZE-1:0] OpAdd   = O_SIZE'(2);
  localparam logic [O_SIZE-1:0] OpAddi  = O_SIZE'(3);
  localparam logic [O_SIZE-1:0] OpMul   = O_SIZE'(4);
  localparam logic [O_SIZE-1:0] OpMuli  = O_SIZE'(5);
  localparam logic [O_SIZE-1:0] OpWait0 = O_SIZE'(6);
  localparam logic [O_SIZE-1:0] OpWait1 = O_SIZE'(7);

  localparam logic [A_SIZE-1:0] AluA   = A_SIZE'(0);
  localparam logic [A_SIZE-1:0] AluB   = A_SIZE'(1);
  localparam logic [A_SIZE-1:0] AluAdd = A_SIZE'(2);
  localparam logic [A_SIZE-1:0] AluMul = A_SIZE'(3);

  // Counter only needs to hold MUL_CYCLES-1.
  localparam int unsigned CntW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {StFetch, StExec, StMulWait, StWaitSw} state_e;

  state_e            state_q, state_d;
  logic [P_SIZE-1:0] pc_q, pc_d, pc_next;
  logic [O_SIZE-1:0] ir_op_q, ir_op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sw8_meta_q, sw8_s_q;
  logic              is_mul, is_wait, wait_level;
  logic              fetch_go;

`ifdef PICO_SINGLE_STEP_EN
  logic step_meta_q, step_s_q, step_prev_q;
  // A press is seen for one cycle only, so presses outside FETCH are lost.
  assign fetch_go = step_s_q & ~step_prev_q;
`else
  assign fetch_go = 1'b1;
`endif

  assign pc_next    = (pc_q == P_SIZE'(PROG_LEN - 1)) ? '0 : pc_q + P_SIZE'(1);
  assign is_mul     = (ir_op_q == OpMul) || (ir_op_q == OpMuli);
  assign is_wait    = (ir_op_q == OpWait0) || (ir_op_q == OpWait1);
  assign wait_level = (ir_op_q == OpWait1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_op_d = ir_op_q;
    cnt_d   = cnt_q;
    reg_we  = 1'b0;
    case (state_q)
      StFetch: begin
        if (fetch_go) begin
          ir_op_d = opcode_in;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_wait) begin
          state_d = StWaitSw;
        end else if (is_mul && (MUL_CYCLES > 1)) begin
          cnt_d   = CntW'(MUL_CYCLES - 1);
          state_d = StMulWait;
        end else begin
          reg_we  = 1'b1;
          pc_d    = pc_next;
          state_d = StFetch;
        end
      end
      StMulWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          reg_we  = 1'b1;
          pc_d    = pc_next;
          state_d = StFetch;
        end
      end
      StWaitSw: begin
        if (sw8_s_q == wait_level) begin
          pc_d    = pc_next;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StFetch;
      pc_q        <= '0;
      ir_op_q     <= OpLdi;
      cnt_q       <= '0;
      sw8_meta_q  <= 1'b0;
      sw8_s_q     <= 1'b0;
`ifdef PICO_SINGLE_STEP_EN
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_op_q     <= ir_op_d;
      cnt_q       <= cnt_d;
      sw8_meta_q  <= sw8;
      sw8_s_q     <= sw8_meta_q;
`ifdef PICO_SINGLE_STEP_EN
      step_meta_q <= step;
      step_s_q    <= step_meta_q;
      step_prev_q <= step_s_q;
`endif
    end
  end

  always_comb begin
    alu_func = AluA;
    imm_sel  = 1'b0;
    sw_sel   = 1'b0;
    case (ir_op_q)
      OpLdi: begin
        alu_func = AluB;
        imm_sel  = 1'b1;
      end
      OpLds: begin
        alu_func = AluB;
        sw_sel   = 1'b1;
      end
      OpAdd:  alu_func = AluAdd;
      OpAddi: begin
        alu_func = AluAdd;
        imm_sel  = 1'b1;
      end
      OpMul:  alu_func = AluMul;
      OpMuli: begin
        alu_func = AluMul;
        imm_sel  = 1'b1;
      end
      default: alu_func = AluA;
    endcase
  end

  assign pc      = pc_q;
  assign ir_op   = ir_op_q;
  assign waiting = (state_q == StWaitSw);

endmodule

// File: tb/tb_pico_sequencer.sv
// Bench for pico_sequencer: directed scenarios, then random programs and switch activity,
// all compared each cycle against an instruction-timeline reference model.
module tb_pico_sequencer;

  localparam int unsigned PSize     = 4;
  localparam int unsigned OSize     = 3;
  localparam int unsigned ASize     = 2;
  localparam int unsigned ProgLen   = 5;
  localparam int unsigned MulCycles = 3;

  localparam logic [2:0] LDI = 3'd0, LDS = 3'd1, ADD = 3'd2, ADDI = 3'd3;
  localparam logic [2:0] MUL = 3'd4, MULI = 3'd5, WAIT0 = 3'd6, WAIT1 = 3'd7;
  localparam logic [1:0] ALU_A = 2'd0, ALU_B = 2'd1, ALU_ADD = 2'd2, ALU_MUL = 2'd3;

  logic             clk = 1'b0;
  logic             nReset;
  logic             sw8;
  logic [OSize-1:0] opcode_in;
  logic [PSize-1:0] pc;
  logic [OSize-1:0] ir_op;
  logic [ASize-1:0] alu_func;
  logic             imm_sel, sw_sel, reg_we, waiting;

  logic [2:0] rom [16];

  assign opcode_in = rom[pc];
  always #5 clk = ~clk;

  pico_sequencer #(
    .P_SIZE    (PSize),
    .O_SIZE    (OSize),
    .A_SIZE    (ASize),
    .PROG_LEN  (ProgLen),
    .MUL_CYCLES(MulCycles)
  ) dut (
    .clk      (clk),
    .nReset   (nReset),
    .opcode_in(opcode_in),
    .sw8      (sw8),
    .pc       (pc),
    .ir_op    (ir_op),
    .alu_func (alu_func),
    .imm_sel  (imm_sel),
    .sw_sel   (sw_sel),
    .reg_we   (reg_we),
    .waiting  (waiting)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: current instruction, cycles spent on it (0 = fetch), switch history.
  int         m_pc;
  logic [2:0] m_ir;
  int         m_phase;
  logic       m_sw_d1, m_sw_d2;

  function automatic logic is_wait(input logic [2:0] op);
    return (op == WAIT0) || (op == WAIT1);
  endfunction

  function automatic int latency(input logic [2:0] op);
    return ((op == MUL) || (op == MULI)) ? 1 + MulCycles : 2;
  endfunction

  function automatic logic [1:0] exp_alu(input logic [2:0] op);
    logic [1:0] tbl [8];
    tbl = '{ALU_B, ALU_B, ALU_ADD, ALU_ADD, ALU_MUL, ALU_MUL, ALU_A, ALU_A};
    return tbl[op];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic exp_we, exp_wait;
    exp_we   = (m_phase != 0) && !is_wait(m_ir) && (m_phase == latency(m_ir) - 1);
    exp_wait = is_wait(m_ir) && (m_phase >= 2);
    check("pc", 32'(pc), 32'(m_pc));
    check("ir_op", 32'(ir_op), 32'(m_ir));
    check("alu_func", 32'(alu_func), 32'(exp_alu(m_ir)));
    check("imm_sel", 32'(imm_sel), 32'(m_ir == LDI || m_ir == ADDI || m_ir == MULI));
    check("sw_sel", 32'(sw_sel), 32'(m_ir == LDS));
    check("reg_we", 32'(reg_we), 32'(exp_we));
    check("waiting", 32'(waiting), 32'(exp_wait));
  endtask

  task automatic model_edge();
    logic done;
    if (m_phase == 0) begin
      m_ir    = rom[m_pc];
      m_phase = 1;
    end else begin
      if (is_wait(m_ir)) done = (m_phase >= 2) && (m_sw_d2 == (m_ir == WAIT1));
      else               done = (m_phase == latency(m_ir) - 1);
      if (done) begin
        m_pc    = (m_pc == ProgLen - 1) ? 0 : m_pc + 1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    m_sw_d2 = m_sw_d1;
    m_sw_d1 = sw8;
  endtask

  // Called at a falling edge: check this cycle, advance through one rising edge.
  task automatic cycle();
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    #1;
    m_pc = 0; m_ir = LDI; m_phase = 0; m_sw_d1 = 1'b0; m_sw_d2 = 1'b0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir_op", 32'(ir_op), 32'(LDI));
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b1;
    sw8    = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = LDI;
    rom[1] = ADD; rom[2] = ADDI; rom[3] = MULI; rom[4] = WAIT1;
    @(negedge clk);
    apply_reset();

    // LDI, ADD, ADDI: writes on cycles 1,3,5, pc reaches 3 on cycle 6
    cycle();
    check("ldi_we", 32'(reg_we), 32'd1);
    check("ldi_alu", 32'(alu_func), 32'(ALU_B));
    check("ldi_imm", 32'(imm_sel), 32'd1);
    cycle(); cycle();
    check("add_we", 32'(reg_we), 32'd1);
    check("add_alu", 32'(alu_func), 32'(ALU_ADD));
    check("add_imm", 32'(imm_sel), 32'd0);
    cycle(); cycle();
    check("addi_alu", 32'(alu_func), 32'(ALU_ADD));
    check("addi_imm", 32'(imm_sel), 32'd1);
    cycle();
    check("pc_after_alu3", 32'(pc), 32'd3);

    // MULI: exec cycles 7..9, single write on cycle 9, pc 4 on cycle 10
    cycle(); cycle();
    check("muli_no_we", 32'(reg_we), 32'd0);
    check("muli_alu", 32'(alu_func), 32'(ALU_MUL));
    cycle();
    check("muli_we", 32'(reg_we), 32'd1);
    cycle();
    check("pc_after_muli", 32'(pc), 32'd4);

    // WAIT1 parks with sw8 low; released 3 edges after sw8 rises, pc wraps to 0
    for (int i = 0; i < 10; i++) cycle();
    check("wait1_parked", 32'(waiting), 32'd1);
    check("wait1_pc_held", 32'(pc), 32'd4);
    sw8 = 1'b1;
    cycle(); cycle();
    check("wait1_still", 32'(pc), 32'd4);
    cycle();
    check("wait1_exit_pc", 32'(pc), 32'd0);
    check("wait1_exit_wait", 32'(waiting), 32'd0);

    // WAIT0 with sw8 already low: one WAITSW cycle
    sw8 = 1'b0;
    rom[0] = WAIT0;
    apply_reset();
    cycle(); cycle();
    check("wait0_one_cycle", 32'(waiting), 32'd1);
    cycle();
    check("wait0_done_pc", 32'(pc), 32'd1);
    check("wait0_done_wait", 32'(waiting), 32'd0);

    // ADD at last address wraps pc
    for (int i = 0; i < 4; i++) rom[i] = LDI;
    rom[4] = ADD;
    apply_reset();
    for (int i = 0; i < 9; i++) cycle();
    check("wrap_add_we", 32'(reg_we), 32'd1);
    cycle();
    check("wrap_pc", 32'(pc), 32'd0);

    // Reset in the write cycle of a MUL kills the write
    rom[1] = MUL;
    apply_reset();
    for (int i = 0; i < 5; i++) cycle();
    check("mul_we_pre_rst", 32'(reg_we), 32'd1);
    check("mul_pc_pre_rst", 32'(pc), 32'd1);
    apply_reset();

    // Random programs and switch activity
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) rom[$urandom_range(ProgLen - 1)] = 3'($urandom_range(7));
      if ($urandom_range(5) == 0) sw8 = ~sw8;
      if (i == 700) apply_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
